// File: rtl/beat_arbiter_pkg.sv
// beat_arb_pkg: shared state type and round-robin helper for the beat-stream arbiters.
package beat_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Successor of idx in a ring of count entries, wrapping from count-1 to 0.
   function automatic logic [31:0] rr_next(input logic [31:0] idx, input logic [31:0] count);
      logic [31:0] nxt;
      if (idx == count - 32'd1) begin
         nxt = 32'd0;
      end else begin
         nxt = idx + 32'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/beat_arbiter_if.sv
// beat_arbiter_if: requester-side beat channels and the shared transport channel.
interface beat_arbiter_if #(
   parameter int width = 32,
   parameter int count = 4
);
   localparam int srcw = $clog2(count);

   logic [count-1:0]       in_req;
   logic [count-1:0]       in__ENA;
   logic [count-1:0]       in__RDY;
   logic [count*width-1:0] in_v;
   logic [count-1:0]       in_last;
   logic                   out__ENA;
   logic                   out__RDY;
   logic [width-1:0]       out_v;
   logic                   out_last;
   logic [srcw-1:0]        out_src;

   // Requesters plus transport sink.
   modport master (output in_req, in__ENA, in_v, in_last, out__RDY,
                   input  in__RDY, out__ENA, out_v, out_last, out_src);

   // The arbiter itself.
   modport slave  (input  in_req, in__ENA, in_v, in_last, out__RDY,
                   output in__RDY, out__ENA, out_v, out_last, out_src);

   // Passive protocol observer.
   modport monitor (input in_req, in__ENA, in__RDY, in_last);
endinterface

// File: rtl/beat_arbiter_chk.sv
// beat_arbiter_chk: protocol observer; latches requester-side violations until reset.
module beat_arbiter_chk #(
   parameter int count = 4
) (
   input  logic                  CLK,
   input  logic                  nRST,
   beat_arbiter_if.monitor       bus,
   output logic                  illegal_ena_r,
   output logic                  req_drop_r
);

   logic [count-1:0] open_r;
   logic [count-1:0] acc_s;

   assign acc_s = bus.in__ENA & bus.in__RDY;

   // Track messages in flight and flag ENA without RDY or req dropped before last.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         open_r        <= {count{1'b0}};
         illegal_ena_r <= 1'b0;
         req_drop_r    <= 1'b0;
      end else begin
         open_r <= (open_r | acc_s) & ~(acc_s & bus.in_last);
         if (|(bus.in__ENA & ~bus.in__RDY)) begin
            illegal_ena_r <= 1'b1;
         end
         if (|(open_r & ~bus.in_req)) begin
            req_drop_r <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/beat_arbiter_rr_pick.sv
// beat_rr_pick: combinational rotating-priority picker; rr has the highest priority,
// priority falls going upward and wraps from count-1 to 0.
module beat_rr_pick #(
   parameter int count = 4,
   localparam int srcw = $clog2(count)
) (
   input  logic [count-1:0] req,
   input  logic [srcw-1:0]  rr,
   output logic             found,
   output logic [srcw-1:0]  idx
);

   logic [31:0]     sum_s;
   logic [srcw-1:0] cand_s;
   logic            hit_s;

   // Scan from lowest to highest priority so the best hit is the last one written.
   always_comb begin
      found  = 1'b0;
      idx    = {srcw{1'b0}};
      sum_s  = 32'd0;
      cand_s = {srcw{1'b0}};
      hit_s  = 1'b0;
      for (int k = count - 1; k >= 0; k--) begin
         sum_s  = 32'(rr) + 32'(k);
         cand_s = (sum_s >= 32'(count)) ? srcw'(sum_s - 32'(count)) : srcw'(sum_s);
         hit_s  = req[cand_s];
         found  = found | hit_s;
         idx    = hit_s ? cand_s : idx;
      end
   end

endmodule

// File: rtl/beat_arbiter.sv
// beat_arbiter: message-level round-robin arbiter sharing one beat-stream channel.
// A grant is locked from a requester's first beat through its last beat; a single
// registered output buffer decouples requester timing from the transport ready.
module beat_arbiter
   import beat_arb_pkg::*;
#(
   parameter int width = 32,
   parameter int count = 4,
   localparam int srcw = $clog2(count)
) (
   input  logic          CLK,
   input  logic          nRST,
   beat_arbiter_if.slave bus
);

   arb_state_t       state_r;
   logic [srcw-1:0]  grant_r;
   logic [srcw-1:0]  rr_r;
   logic             obuf_valid_r;
   logic [width-1:0] obuf_v_r;
   logic             obuf_last_r;
   logic [srcw-1:0]  obuf_src_r;

   logic             pick_found_s;
   logic [srcw-1:0]  pick_idx_s;
   logic             space_s;
   logic             accept_s;
   logic             accept_last_s;
   logic [count-1:0] in_rdy_s;
   logic [width-1:0] beat_v_s;

   beat_rr_pick #(
      .count (count)
   ) u_pick (
      .req   (bus.in_req),
      .rr    (rr_r),
      .found (pick_found_s),
      .idx   (pick_idx_s)
   );

   // Decode ready, acceptance and beat payload for the locked requester.
   always_comb begin
      space_s            = !obuf_valid_r || bus.out__RDY;
      in_rdy_s           = {count{1'b0}};
      in_rdy_s[grant_r]  = (state_r == BUSY) && space_s;
      accept_s           = (state_r == BUSY) && space_s && bus.in__ENA[grant_r];
      accept_last_s      = accept_s && bus.in_last[grant_r];
      beat_v_s           = bus.in_v[grant_r*width +: width];
   end

   assign bus.in__RDY  = in_rdy_s;
   assign bus.out__ENA = obuf_valid_r && bus.out__RDY;
   assign bus.out_v    = obuf_v_r;
   assign bus.out_last = obuf_last_r;
   assign bus.out_src  = obuf_src_r;

   // Arbitration FSM: pick in IDLE, hold the grant until its last beat is accepted.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         state_r <= IDLE;
         grant_r <= {srcw{1'b0}};
         rr_r    <= {srcw{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_found_s) begin
                  grant_r <= pick_idx_s;
                  state_r <= BUSY;
               end
            end
            BUSY: begin
               if (accept_last_s) begin
                  rr_r    <= srcw'(rr_next(32'(grant_r), 32'(count)));
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Output buffer: a load wins over a drain, so load-and-transfer keeps it full.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         obuf_valid_r <= 1'b0;
         obuf_v_r     <= {width{1'b0}};
         obuf_last_r  <= 1'b0;
         obuf_src_r   <= {srcw{1'b0}};
      end else begin
         if (accept_s) begin
            obuf_valid_r <= 1'b1;
            obuf_v_r     <= beat_v_s;
            obuf_last_r  <= bus.in_last[grant_r];
            obuf_src_r   <= grant_r;
         end else if (obuf_valid_r && bus.out__RDY) begin
            obuf_valid_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_beat_arbiter.sv
// tb_beat_arbiter: scenario tasks with a message-level round-robin reference model.
module tb_beat_arbiter;

   typedef struct {
      int          cyc;
      int          src;
      logic [31:0] v;
      logic        last;
   } beat_t;

   logic CLK;
   logic nRST;
   logic chk_illegal;
   logic chk_drop;

   int checks;
   int errors;
   int cyc;

   logic [3:0]  hold_req;
   logic [3:0]  force_ena;
   logic [31:0] force_v;

   beat_t pend_q [4][$];
   beat_t xfer_q [$];
   beat_t acc_q  [$];
   beat_t exp_q  [$];

   beat_arbiter_if #(.width(32), .count(4)) bus ();

   beat_arbiter #(.width(32), .count(4)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   beat_arbiter_chk #(.count(4)) chk (
      .CLK           (CLK),
      .nRST          (nRST),
      .bus           (bus),
      .illegal_ena_r (chk_illegal),
      .req_drop_r    (chk_drop)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One clock cycle: drive requesters from their queues, sample at negedge, log.
   task automatic step(input logic ordy, output logic [3:0] rdy_seen);
      beat_t b;
      bus.out__RDY = ordy;
      for (int i = 0; i < 4; i++) bus.in_req[i] = (pend_q[i].size() != 0) || hold_req[i];
      #1;
      for (int i = 0; i < 4; i++) begin
         if (force_ena[i]) begin
            bus.in__ENA[i] = 1'b1; bus.in_v[i*32 +: 32] = force_v; bus.in_last[i] = 1'b1;
         end else if (bus.in__RDY[i] === 1'b1 && pend_q[i].size() != 0) begin
            bus.in__ENA[i] = 1'b1;
            bus.in_v[i*32 +: 32] = pend_q[i][0].v;
            bus.in_last[i] = pend_q[i][0].last;
         end else begin
            bus.in__ENA[i] = 1'b0; bus.in_last[i] = 1'b0;
         end
      end
      @(negedge CLK);
      rdy_seen = bus.in__RDY;
      if (bus.out__ENA === 1'b1) begin
         b.cyc = cyc; b.src = int'(bus.out_src); b.v = bus.out_v; b.last = bus.out_last;
         xfer_q.push_back(b);
      end
      for (int i = 0; i < 4; i++) begin
         if (bus.in__ENA[i] === 1'b1 && bus.in__RDY[i] === 1'b1 && nRST == 1'b0) begin
            b.cyc = cyc; b.src = i; b.v = bus.in_v[i*32 +: 32]; b.last = bus.in_last[i];
            acc_q.push_back(b);
            if (!force_ena[i]) void'(pend_q[i].pop_front());
         end
      end
      @(posedge CLK); #1;
      cyc++;
   endtask

   task automatic add_msg(input int i, input logic [31:0] base, input int n, input bit rnd);
      beat_t b;
      for (int j = 0; j < n; j++) begin
         b.cyc = 0; b.src = i; b.v = rnd ? $urandom : base + 32'(j); b.last = (j == n - 1);
         pend_q[i].push_back(b);
      end
   endtask

   task automatic clear_logs();
      xfer_q.delete(); acc_q.delete(); exp_q.delete();
      for (int i = 0; i < 4; i++) pend_q[i].delete();
   endtask

   task automatic do_reset();
      logic [3:0] r;
      clear_logs();
      nRST = 1'b1;
      step(1'b1, r); step(1'b1, r);
      nRST = 1'b0;
      clear_logs();
   endtask

   task automatic run_until(input int n, input int bound, input int rdy_pct);
      logic [3:0] r;
      for (int k = 0; k < bound && xfer_q.size() < n; k++)
         step(($urandom_range(0, 99) < rdy_pct) ? 1'b1 : 1'b0, r);
   endtask

   // Reference: whole messages, next = first pending requester at or after rr.
   function automatic void build_expected(input int rr0);
      beat_t tmp [4][$];
      beat_t b;
      int rr, pick;
      bit done;
      exp_q.delete();
      for (int i = 0; i < 4; i++) tmp[i] = pend_q[i];
      rr = rr0;
      pick = 0;
      while (pick >= 0) begin
         pick = -1;
         for (int k = 0; k < 4; k++)
            if (pick < 0 && tmp[(rr + k) % 4].size() != 0) pick = (rr + k) % 4;
         if (pick >= 0) begin
            done = 1'b0;
            while (!done && tmp[pick].size() != 0) begin
               b = tmp[pick].pop_front();
               exp_q.push_back(b);
               done = b.last;
            end
            rr = (pick + 1) % 4;
         end
      end
   endfunction

   task automatic test_reset();
      do_reset();
      bus.out__RDY = 1'b1;
      #1;
      checks++; if (bus.out__ENA !== 1'b0) begin errors++; $display("FAIL reset_out_ena got %b want 0", bus.out__ENA); end
      checks++; if (bus.in__RDY !== 4'b0000) begin errors++; $display("FAIL reset_in_rdy got %b want 0000", bus.in__RDY); end
      checks++; if (bus.out_v !== 32'd0 || bus.out_last !== 1'b0 || bus.out_src !== 2'd0) begin
         errors++; $display("FAIL reset_obuf got v=%h last=%b src=%0d want 0/0/0", bus.out_v, bus.out_last, bus.out_src); end
      checks++; if (dut.rr_r !== 2'd0) begin errors++; $display("FAIL reset_rr got %0d want 0", dut.rr_r); end
   endtask

   task automatic test_single();
      int c0;
      do_reset();
      add_msg(0, 32'h11, 3, 1'b0);
      pend_q[0][1].v = 32'h22; pend_q[0][2].v = 32'h33;
      build_expected(0);
      c0 = cyc;
      run_until(3, 30, 100);
      checks++; if (xfer_q.size() != 3 || acc_q.size() != 3) begin errors++;
         $display("FAIL single_count got xfer=%0d acc=%0d want 3/3", xfer_q.size(), acc_q.size()); end
      for (int k = 0; k < 3 && k < xfer_q.size() && k < acc_q.size(); k++) begin
         checks++;
         if (xfer_q[k].src !== exp_q[k].src || xfer_q[k].v !== exp_q[k].v || xfer_q[k].last !== exp_q[k].last) begin errors++;
            $display("FAIL single_beat%0d got src=%0d v=%h last=%b want src=%0d v=%h last=%b", k,
                     xfer_q[k].src, xfer_q[k].v, xfer_q[k].last, exp_q[k].src, exp_q[k].v, exp_q[k].last); end
         checks++;
         if (xfer_q[k].cyc != acc_q[k].cyc + 1 || acc_q[k].cyc != c0 + 1 + k) begin errors++;
            $display("FAIL single_latency%0d got acc=%0d out=%0d want acc=%0d out=%0d", k,
                     acc_q[k].cyc, xfer_q[k].cyc, c0 + 1 + k, c0 + 2 + k); end
      end
   endtask

   task automatic test_contention();
      logic [3:0] r;
      do_reset();
      add_msg(2, 32'h21, 3, 1'b0);
      add_msg(0, 32'h01, 3, 1'b0);
      build_expected(0);
      run_until(6, 40, 100);
      step(1'b1, r);
      checks++; if (xfer_q.size() != 6) begin errors++; $display("FAIL contention_count got %0d want 6", xfer_q.size()); end
      for (int k = 0; k < 6 && k < xfer_q.size(); k++) begin
         checks++;
         if (xfer_q[k].src !== exp_q[k].src || xfer_q[k].v !== exp_q[k].v || xfer_q[k].last !== exp_q[k].last) begin errors++;
            $display("FAIL contention_beat%0d got src=%0d v=%h want src=%0d v=%h", k,
                     xfer_q[k].src, xfer_q[k].v, exp_q[k].src, exp_q[k].v); end
      end
      checks++; if (acc_q.size() != 6 || acc_q[3].cyc != acc_q[2].cyc + 2) begin errors++;
         $display("FAIL contention_gap got acc=%0d want 6 with one dead cycle", acc_q.size()); end
      checks++; if (dut.rr_r !== 2'd3) begin errors++; $display("FAIL contention_rr got %0d want 3", dut.rr_r); end
   endtask

   task automatic test_fairness();
      logic [3:0] r;
      do_reset();
      for (int i = 0; i < 4; i++) add_msg(i, 32'h10 + 32'(i), 1, 1'b0);
      add_msg(0, 32'h20, 1, 1'b0);
      add_msg(1, 32'h21, 1, 1'b0);
      build_expected(0);
      run_until(6, 40, 100);
      step(1'b1, r); step(1'b1, r);
      checks++; if (xfer_q.size() != 6) begin errors++; $display("FAIL fair_count got %0d want 6", xfer_q.size()); end
      for (int k = 0; k < 6 && k < xfer_q.size(); k++) begin
         checks++;
         if (xfer_q[k].src !== exp_q[k].src || xfer_q[k].v !== exp_q[k].v) begin errors++;
            $display("FAIL fair_src%0d got src=%0d v=%h want src=%0d v=%h", k,
                     xfer_q[k].src, xfer_q[k].v, exp_q[k].src, exp_q[k].v); end
         if (k > 0) begin
            checks++;
            if (xfer_q[k].cyc != xfer_q[k-1].cyc + 2) begin errors++;
               $display("FAIL fair_gap%0d got %0d want 2", k, xfer_q[k].cyc - xfer_q[k-1].cyc); end
         end
      end
   endtask

   // Runs straight after fairness, so the pointer starts at 2 and must be cleared.
   task automatic test_reset_mid();
      logic [3:0] r;
      int xs;
      clear_logs();
      add_msg(0, 32'h50, 4, 1'b0);
      add_msg(1, 32'h77, 1, 1'b0);
      checks++; if (dut.rr_r !== 2'd2) begin errors++; $display("FAIL rstmid_rr_before got %0d want 2", dut.rr_r); end
      for (int k = 0; k < 20 && acc_q.size() < 2; k++) step(1'b1, r);
      checks++; if (acc_q.size() != 2 || acc_q[0].src != 0) begin errors++;
         $display("FAIL rstmid_prefix got %0d beats want 2 from src0", acc_q.size()); end
      pend_q[0].delete();
      hold_req[0] = 1'b1;
      add_msg(3, 32'h3F, 1, 1'b0);
      nRST = 1'b1;
      step(1'b1, r);
      nRST = 1'b0;
      hold_req = 4'b0000;
      xs = xfer_q.size();
      step(1'b1, r);
      checks++; if (xfer_q.size() != xs || r !== 4'b0000 || dut.rr_r !== 2'd0) begin errors++;
         $display("FAIL rstmid_after got xfers=%0d rdy=%b rr=%0d want 0/0000/0", xfer_q.size() - xs, r, dut.rr_r); end
      step(1'b1, r);
      checks++; if (r !== 4'b0010) begin errors++; $display("FAIL rstmid_regrant got rdy=%b want 0010", r); end
      step(1'b1, r);
      checks++; if (xfer_q.size() != xs + 1 || xfer_q[xfer_q.size()-1].v !== 32'h77 || xfer_q[xfer_q.size()-1].src != 1) begin
         errors++; $display("FAIL rstmid_beat got %0d new beats want one 0x77 from src1", xfer_q.size() - xs); end
      run_until(xs + 2, 10, 100);
   endtask

   task automatic test_backpressure();
      logic [3:0] r;
      logic [3:0] rseen [12];
      do_reset();
      add_msg(0, 32'hA0, 4, 1'b0);
      build_expected(0);
      for (int k = 0; k < 12; k++) begin
         step((k >= 3 && k < 8) ? 1'b0 : 1'b1, r);
         rseen[k] = r;
      end
      for (int k = 3; k < 8; k++) begin
         checks++; if (rseen[k] !== 4'b0000) begin errors++; $display("FAIL bp_stall_rdy%0d got %b want 0000", k, rseen[k]); end
      end
      checks++; if (rseen[8] !== 4'b0001) begin errors++; $display("FAIL bp_resume got %b want 0001", rseen[8]); end
      checks++; if (xfer_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", xfer_q.size()); end
      for (int k = 0; k < 4 && k < xfer_q.size(); k++) begin
         checks++;
         if (xfer_q[k].v !== exp_q[k].v || xfer_q[k].last !== exp_q[k].last) begin errors++;
            $display("FAIL bp_beat%0d got v=%h last=%b want v=%h last=%b", k,
                     xfer_q[k].v, xfer_q[k].last, exp_q[k].v, exp_q[k].last); end
      end
   endtask

   task automatic test_illegal_ena();
      logic [3:0] r;
      do_reset();
      add_msg(1, 32'h61, 3, 1'b0);
      build_expected(0);
      checks++; if (chk_illegal !== 1'b0) begin errors++; $display("FAIL illegal_flag_pre got %b want 0", chk_illegal); end
      step(1'b1, r);
      force_ena = 4'b1000; force_v = 32'hDEAD;
      for (int k = 0; k < 3; k++) step(1'b1, r);
      force_ena = 4'b0000;
      run_until(3, 20, 100);
      checks++; if (xfer_q.size() != 3) begin errors++; $display("FAIL illegal_count got %0d want 3", xfer_q.size()); end
      for (int k = 0; k < 3 && k < xfer_q.size(); k++) begin
         checks++;
         if (xfer_q[k].v !== exp_q[k].v || xfer_q[k].src != 1) begin errors++;
            $display("FAIL illegal_beat%0d got src=%0d v=%h want src=1 v=%h", k, xfer_q[k].src, xfer_q[k].v, exp_q[k].v); end
      end
      checks++; if (chk_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got %b want 1", chk_illegal); end
   endtask

   task automatic test_random();
      for (int rep = 0; rep < 4; rep++) begin
         do_reset();
         for (int i = 0; i < 4; i++)
            for (int m = $urandom_range(0, 2); m > 0; m--) add_msg(i, 32'd0, $urandom_range(1, 4), 1'b1);
         build_expected(0);
         run_until(exp_q.size(), 400, 70);
         run_until(exp_q.size() + 1, 4, 100);
         checks++; if (xfer_q.size() != exp_q.size()) begin errors++;
            $display("FAIL rand%0d_count got %0d want %0d", rep, xfer_q.size(), exp_q.size()); end
         for (int k = 0; k < exp_q.size() && k < xfer_q.size(); k++) begin
            checks++;
            if (xfer_q[k].src !== exp_q[k].src || xfer_q[k].v !== exp_q[k].v || xfer_q[k].last !== exp_q[k].last) begin errors++;
               $display("FAIL rand%0d_beat%0d got src=%0d v=%h last=%b want src=%0d v=%h last=%b", rep, k,
                        xfer_q[k].src, xfer_q[k].v, xfer_q[k].last, exp_q[k].src, exp_q[k].v, exp_q[k].last); end
         end
         checks++; if (chk_illegal !== 1'b0 || chk_drop !== 1'b0) begin errors++;
            $display("FAIL rand%0d_protocol got illegal=%b drop=%b want 0/0", rep, chk_illegal, chk_drop); end
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      nRST = 1'b1; hold_req = 4'b0000; force_ena = 4'b0000; force_v = 32'd0;
      bus.in_req = 4'b0000; bus.in__ENA = 4'b0000; bus.in_v = 128'd0; bus.in_last = 4'b0000;
      bus.out__RDY = 1'b0;
      @(posedge CLK); #1;
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_reset_mid();
      test_backpressure();
      test_illegal_ena();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
